// File: rtl/pkt_buffer_writer_if.sv
// pkt_buffer_writer_if: arbiter stream, descriptor queue, buffer readback and status signals
interface pkt_buffer_writer_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = 8,
    parameter int NUM_QUEUES = 4,
    parameter int BUF_AW     = 9,
    parameter int LEN_W      = 8
);
    logic [DATA_WIDTH-1:0]            in_data;
    logic [CTRL_WIDTH-1:0]            in_ctrl;
    logic                             in_wr;
    logic [NUM_QUEUES-1:0]            in_scr_port;
    logic                             sof;
    logic                             eop;
    logic                             in_rdy;
    logic                             desc_valid;
    logic                             desc_rd;
    logic [BUF_AW-1:0]                desc_addr;
    logic [LEN_W-1:0]                 desc_len;
    logic [NUM_QUEUES-1:0]            desc_src_port;
    logic [BUF_AW-1:0]                buf_rd_addr;
    logic [CTRL_WIDTH+DATA_WIDTH-1:0] buf_rd_data;
    logic                             free_en;
    logic [LEN_W-1:0]                 free_len;
    logic [15:0]                      drop_cnt;
    logic [15:0]                      err_cnt;
    modport master (
        output in_data, in_ctrl, in_wr, in_scr_port, sof, eop, desc_rd, buf_rd_addr, free_en, free_len,
        input  in_rdy, desc_valid, desc_addr, desc_len, desc_src_port, buf_rd_data, drop_cnt, err_cnt
    );
    modport slave (
        input  in_data, in_ctrl, in_wr, in_scr_port, sof, eop, desc_rd, buf_rd_addr, free_en, free_len,
        output in_rdy, desc_valid, desc_addr, desc_len, desc_src_port, buf_rd_data, drop_cnt, err_cnt
    );
endinterface

// File: rtl/pkt_buffer_writer.sv
// pkt_buffer_writer: writes arbiter frames into a circular buffer and queues one descriptor per good frame
module pkt_buffer_writer #(
    parameter int DATA_WIDTH    = 64,
    parameter int CTRL_WIDTH    = 8,
    parameter int NUM_QUEUES    = 4,
    parameter int BUF_AW        = 9,
    parameter int LEN_W         = 8,
    parameter int MAX_PKT_WORDS = 190,
    parameter int DESC_AW       = 3
) (
    input  logic               clk,
    input  logic               reset,
    pkt_buffer_writer_if.slave bus
);
    localparam int BUF_DEPTH  = 1 << BUF_AW;
    localparam int DESC_DEPTH = 1 << DESC_AW;
    localparam int WORD_W     = CTRL_WIDTH + DATA_WIDTH;
    localparam int DESC_W     = BUF_AW + LEN_W + NUM_QUEUES;

    typedef enum logic [1:0] {IDLE, WRITE, DROP} state_t;

    state_t                r_state, w_state_n;
    logic [WORD_W-1:0]     r_mem [BUF_DEPTH];
    logic [DESC_W-1:0]     r_dmem [DESC_DEPTH];
    logic [WORD_W-1:0]     r_rd_data;
    logic [BUF_AW-1:0]     r_wr_ptr, r_start, w_start_n, w_wa;
    logic [LEN_W-1:0]      r_len, w_len_n;
    logic [NUM_QUEUES-1:0] r_src, w_src_n;
    logic [BUF_AW:0]       r_used, w_used_n;
    logic [BUF_AW+1:0]     w_add, w_sub;
    logic [DESC_AW-1:0]    r_dwp, r_drp;
    logic [DESC_AW:0]      r_dcnt, w_dcnt_n;
    logic [15:0]           r_drop_cnt, r_err_cnt;
    logic [16:0]           w_drop_sum;
    logic [1:0]            w_drop_inc;
    logic                  r_in_rdy, w_we, w_rewind, w_push, w_pop, w_err, w_room, w_desc_room, w_abort, w_ok;

    assign w_pop       = bus.desc_rd && (r_dcnt != '0);
    assign w_room      = r_used != (BUF_AW+1)'(BUF_DEPTH);
    assign w_desc_room = (r_dcnt != (DESC_AW+1)'(DESC_DEPTH)) || w_pop;

    // Next-state and per-word actions; a word that cannot be stored kills its frame
    always_comb begin
        w_state_n  = r_state;
        w_we       = 1'b0;
        w_rewind   = 1'b0;
        w_push     = 1'b0;
        w_err      = 1'b0;
        w_abort    = 1'b0;
        w_ok       = 1'b0;
        w_drop_inc = 2'd0;
        w_wa       = r_wr_ptr;
        w_start_n  = r_start;
        w_len_n    = r_len;
        w_src_n    = r_src;
        if (bus.in_wr && bus.sof) begin
            w_abort    = r_state == WRITE;
            w_wa       = w_abort ? r_start : r_wr_ptr;
            w_ok       = (w_room || w_abort) && (!bus.eop || w_desc_room);
            w_rewind   = w_abort;
            w_we       = w_ok;
            w_push     = w_ok && bus.eop;
            w_start_n  = w_wa;
            w_src_n    = bus.in_scr_port;
            w_len_n    = LEN_W'(1);
            w_drop_inc = {1'b0, w_abort} + {1'b0, !w_ok};
            w_state_n  = bus.eop ? IDLE : (w_ok ? WRITE : DROP);
        end else if (bus.in_wr && r_state == WRITE) begin
            w_ok       = (r_len != LEN_W'(MAX_PKT_WORDS)) && w_room && (!bus.eop || w_desc_room);
            w_we       = w_ok;
            w_push     = w_ok && bus.eop;
            w_rewind   = !w_ok;
            w_len_n    = r_len + LEN_W'(1);
            w_drop_inc = {1'b0, !w_ok};
            w_state_n  = bus.eop ? IDLE : (w_ok ? WRITE : DROP);
        end else if (bus.in_wr) begin
            w_err     = r_state == IDLE;
            w_state_n = bus.eop ? IDLE : r_state;
        end
    end

    assign w_add      = (BUF_AW+2)'(r_used) + (BUF_AW+2)'(w_we);
    assign w_sub      = (BUF_AW+2)'(bus.free_en ? bus.free_len : '0) + (BUF_AW+2)'(w_rewind ? r_len : '0);
    assign w_used_n   = w_add > w_sub ? (BUF_AW+1)'(w_add - w_sub) : '0;
    assign w_dcnt_n   = r_dcnt + (DESC_AW+1)'(w_push) - (DESC_AW+1)'(w_pop);
    assign w_drop_sum = 17'(r_drop_cnt) + 17'(w_drop_inc);

    // FSM state register
    always_ff @(posedge clk) begin
        r_state <= reset ? IDLE : w_state_n;
    end

    // Frame context, write pointer, occupancy, descriptor pointers, counters and registered ready
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_start    <= '0;
            r_len      <= '0;
            r_src      <= '0;
            r_used     <= '0;
            r_dwp      <= '0;
            r_drp      <= '0;
            r_dcnt     <= '0;
            r_drop_cnt <= '0;
            r_err_cnt  <= '0;
            r_in_rdy   <= 1'b0;
        end else begin
            r_wr_ptr   <= w_we ? w_wa + BUF_AW'(1) : (w_rewind ? r_start : r_wr_ptr);
            r_start    <= w_start_n;
            r_len      <= w_len_n;
            r_src      <= w_src_n;
            r_used     <= w_used_n;
            r_dwp      <= w_push ? r_dwp + DESC_AW'(1) : r_dwp;
            r_drp      <= w_pop ? r_drp + DESC_AW'(1) : r_drp;
            r_dcnt     <= w_dcnt_n;
            r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
            r_err_cnt  <= r_err_cnt + 16'(w_err && r_err_cnt != 16'hFFFF);
            r_in_rdy   <= (w_used_n <= (BUF_AW+1)'(BUF_DEPTH - 4)) && (w_dcnt_n <= (DESC_AW+1)'(DESC_DEPTH - 2));
        end
    end

    // Buffer RAM write port
    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_wa] <= {bus.in_ctrl, bus.in_data};
    end

    // Buffer RAM registered read port; a same-address write returns the old word
    always_ff @(posedge clk) begin
        r_rd_data <= reset ? '0 : r_mem[bus.buf_rd_addr];
    end

    // Descriptor FIFO storage, written in the eop cycle
    always_ff @(posedge clk) begin
        if (w_push) r_dmem[r_dwp] <= {w_start_n, w_len_n, w_src_n};
    end

    assign bus.in_rdy      = r_in_rdy;
    assign bus.desc_valid  = r_dcnt != '0;
    assign {bus.desc_addr, bus.desc_len, bus.desc_src_port} = r_dmem[r_drp];
    assign bus.buf_rd_data = r_rd_data;
    assign bus.drop_cnt    = r_drop_cnt;
    assign bus.err_cnt     = r_err_cnt;
endmodule

// File: tb/tb_pkt_buffer_writer.sv
// tb_pkt_buffer_writer: randomized frame-level check of pkt_buffer_writer against a queue/array reference model
module tb_pkt_buffer_writer;
    localparam int BUF_DEPTH = 512;
    localparam int MAX_W     = 190;

    typedef struct {int addr; int len; int src;} desc_t;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    int          n_chk  = 0;
    int          n_fail = 0;
    int          m_ptr  = 0;
    int          m_drop = 0;
    int          m_err  = 0;
    logic [71:0] m_mem [BUF_DEPTH];
    desc_t       m_q [$];

    pkt_buffer_writer_if bus ();
    pkt_buffer_writer dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.in_wr = 0; bus.sof = 0; bus.eop = 0; bus.in_data = '0; bus.in_ctrl = '0; bus.in_scr_port = '0;
        bus.desc_rd = 0; bus.buf_rd_addr = '0; bus.free_en = 0; bus.free_len = '0;
    endtask

    task automatic send_word(input bit s, input bit e, input int src, output logic [71:0] w);
        int t = 0;
        while (!bus.in_rdy && t < 50) begin tick(); t++; end
        if (!bus.in_rdy) check("in_rdy_wait", bus.in_rdy, 1);
        if ($urandom_range(3) == 0) tick();
        w = {8'($urandom()), 32'($urandom()), 32'($urandom())};
        bus.in_wr = 1; bus.sof = s; bus.eop = e; bus.in_scr_port = 4'(src);
        {bus.in_ctrl, bus.in_data} = w;
        tick();
        bus.in_wr = 0; bus.sof = 0; bus.eop = 0;
    endtask

    // cut=1 sends the frame without eop so the next sof aborts it
    task automatic send_frame(input int len, input int src, input bit cut);
        logic [71:0] w;
        int base = m_ptr;
        for (int i = 0; i < len; i++) begin
            send_word(i == 0, !cut && i == len - 1, src, w);
            if (i < MAX_W) m_mem[(base + i) % BUF_DEPTH] = w;
        end
        if (cut || len > MAX_W) m_drop++;
        else begin
            m_q.push_back('{base, len, src});
            m_ptr = (base + len) % BUF_DEPTH;
        end
    endtask

    task automatic pop_one(input bit chk_rdy);
        desc_t e;
        int t = 0;
        while (!bus.desc_valid && t < 10) begin tick(); t++; end
        check("desc_valid", bus.desc_valid, 1);
        e = m_q.pop_front();
        check("desc_addr", bus.desc_addr, e.addr);
        check("desc_len", bus.desc_len, e.len);
        check("desc_src", bus.desc_src_port, e.src);
        bus.desc_rd = 1;
        tick();
        bus.desc_rd = 0;
        if (chk_rdy) begin
            t = 0;
            while (!bus.in_rdy && t < 2) begin tick(); t++; end
            check("in_rdy_after_pop", bus.in_rdy, 1);
        end
        for (int i = 0; i < e.len; i++) begin
            bus.buf_rd_addr = 9'((e.addr + i) % BUF_DEPTH);
            tick();
            check("buf_rd_data", bus.buf_rd_data, m_mem[(e.addr + i) % BUF_DEPTH]);
        end
        bus.free_en = 1; bus.free_len = 8'(e.len);
        tick();
        bus.free_en = 0;
    endtask

    task automatic drain();
        while (m_q.size() > 0) pop_one(0);
        check("desc_empty", bus.desc_valid, 0);
    endtask

    task automatic do_reset();
        reset = 1;
        clear_inputs();
        repeat (3) tick();
        check("rst_in_rdy", bus.in_rdy, 0);
        check("rst_desc_valid", bus.desc_valid, 0);
        check("rst_buf_rd_data", bus.buf_rd_data, 0);
        check("rst_drop_cnt", bus.drop_cnt, 0);
        check("rst_err_cnt", bus.err_cnt, 0);
        reset = 0;
        m_ptr = 0; m_drop = 0; m_err = 0;
        m_q.delete();
        tick();
        check("in_rdy_up", bus.in_rdy, 1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [71:0] w;
        int len;
        clear_inputs();
        do_reset();
        send_frame(3, 2, 0);
        check("desc_valid_after_eop", bus.desc_valid, 1);
        drain();
        send_frame(1, 5, 0);
        check("single_word_desc", bus.desc_valid, 1);
        drain();
        while (m_ptr != 510) begin
            len = $urandom_range((510 - m_ptr) < MAX_W ? 510 - m_ptr : MAX_W, 1);
            send_frame(len, $urandom_range(15), 0);
            drain();
        end
        send_frame(4, 7, 0);
        drain();
        send_frame(191, 3, 0);
        check("oversize_drop_cnt", bus.drop_cnt, m_drop);
        check("oversize_no_desc", bus.desc_valid, 0);
        send_frame(5, 1, 0);
        drain();
        for (int k = 0; k < 7; k++) send_frame(1, k, 0);
        check("desc_full_in_rdy", bus.in_rdy, 0);
        pop_one(1);
        drain();
        send_frame(2, 4, 1);
        do_reset();
        check("mid_frame_reset_no_desc", bus.desc_valid, 0);
        send_word(0, 0, 0, w);
        m_err++;
        send_frame(3, 8, 1);
        send_frame(4, 9, 0);
        drain();
        check("abort_drop_cnt", bus.drop_cnt, m_drop);
        check("stray_err_cnt", bus.err_cnt, m_err);
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(9))
                0: begin
                    send_word(0, 1'($urandom_range(1)), 0, w);
                    m_err++;
                end
                1: begin
                    send_frame($urandom_range(30, 1), $urandom_range(15), 1);
                    send_frame($urandom_range(20, 1), $urandom_range(15), 0);
                end
                2: send_frame($urandom_range(200, 191), $urandom_range(15), 0);
                default: send_frame($urandom_range(40, 1), $urandom_range(15), 0);
            endcase
            if (m_q.size() >= 5 || $urandom_range(2) == 0) drain();
        end
        drain();
        check("final_drop_cnt", bus.drop_cnt, m_drop);
        check("final_err_cnt", bus.err_cnt, m_err);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
